// File: rtl/ncl_dualrail_wavefront_src.sv
// ncl_dualrail_wavefront_src
// Clocked source for NCL threshold-gate pipelines. Takes single-rail words on
// a valid/ready handshake and drives each one as a dual-rail DATA wavefront,
// then returns the rails to NULL. Sequencing follows the downstream completion
// acknowledge ki (1 = request-for-data, 0 = request-for-null). A per-phase
// watchdog flags a stuck handshake and parks the block in ERR until err_clr.
module ncl_dualrail_wavefront_src #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] rail1,
   output logic [WIDTH-1:0] rail0,
   input  logic             ki,
   input  logic             err_clr,
   output logic             busy,
   output logic             timeout_err,
   output logic [CNT_W-1:0] wave_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_NULL = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   // The watchdog fires on the cycle the counter would step onto TIMEOUT.
   localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] WAVE_ONE = CNT_W'(1);

   state_t           state_q;
   logic             ki_meta_q;
   logic             ki_s_q;
   logic [WIDTH-1:0] rail1_q;
   logic [WIDTH-1:0] rail0_q;
   logic             busy_q;
   logic             tmo_err_q;
   logic [CNT_W-1:0] wave_cnt_q;
   logic [15:0]      tmo_cnt_q;
   logic             accept;
   logic             tmo_hit;

   // Bring the asynchronous acknowledge into the clock domain (2-flop sync).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ki_meta_q <= 1'b0;
         ki_s_q    <= 1'b0;
      end else begin
         ki_meta_q <= ki;
         ki_s_q    <= ki_meta_q;
      end
   end

   // Ready only while idle and the downstream is requesting data.
   always_comb begin
      in_ready = 1'b0;
      if (state_q == ST_IDLE) begin
         in_ready = ki_s_q;
      end else begin
         in_ready = 1'b0;
      end
   end

   // Decode the handshake and watchdog conditions used by the FSM.
   always_comb begin
      accept  = in_valid & in_ready;
      tmo_hit = 1'b0;
      if (tmo_cnt_q == TMO_LAST) begin
         tmo_hit = 1'b1;
      end else begin
         tmo_hit = 1'b0;
      end
   end

   // Wavefront FSM: rails, busy, sticky error, wave counter and watchdog.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rail1_q    <= '0;
         rail0_q    <= '0;
         busy_q     <= 1'b0;
         tmo_err_q  <= 1'b0;
         wave_cnt_q <= '0;
         tmo_cnt_q  <= 16'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  // The rails themselves hold the latched word for the DATA phase.
                  state_q   <= ST_DATA;
                  rail1_q   <= in_data;
                  rail0_q   <= ~in_data;
                  busy_q    <= 1'b1;
                  tmo_cnt_q <= 16'd0;
               end
            end
            ST_DATA: begin
               // An expected ki transition wins over a simultaneous timeout.
               if (!ki_s_q) begin
                  state_q   <= ST_NULL;
                  rail1_q   <= '0;
                  rail0_q   <= '0;
                  tmo_cnt_q <= 16'd0;
               end else if (tmo_hit) begin
                  state_q   <= ST_ERR;
                  rail1_q   <= '0;
                  rail0_q   <= '0;
                  busy_q    <= 1'b0;
                  tmo_err_q <= 1'b1;
                  tmo_cnt_q <= 16'd0;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 16'd1;
               end
            end
            ST_NULL: begin
               if (ki_s_q) begin
                  state_q    <= ST_IDLE;
                  busy_q     <= 1'b0;
                  wave_cnt_q <= wave_cnt_q + WAVE_ONE;
                  tmo_cnt_q  <= 16'd0;
               end else if (tmo_hit) begin
                  state_q   <= ST_ERR;
                  busy_q    <= 1'b0;
                  tmo_err_q <= 1'b1;
                  tmo_cnt_q <= 16'd0;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 16'd1;
               end
            end
            ST_ERR: begin
               if (err_clr) begin
                  state_q   <= ST_IDLE;
                  tmo_err_q <= 1'b0;
                  tmo_cnt_q <= 16'd0;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               rail1_q   <= '0;
               rail0_q   <= '0;
               busy_q    <= 1'b0;
               tmo_cnt_q <= 16'd0;
            end
         endcase
      end
   end

   assign rail1       = rail1_q;
   assign rail0       = rail0_q;
   assign busy        = busy_q;
   assign timeout_err = tmo_err_q;
   assign wave_cnt    = wave_cnt_q;

endmodule

// File: tb/tb_ncl_dualrail_wavefront_src.sv
// Bench for ncl_dualrail_wavefront_src: the stimulus thread pushes every
// accepted word into a queue; a separate monitor thread pops it when a DATA
// wavefront appears on the rails and checks the dual-rail encoding.
module tb_ncl_dualrail_wavefront_src;
   localparam int W   = 4;
   localparam int TMO = 8;
   localparam int CW  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic [W-1:0]  rail1;
   logic [W-1:0]  rail0;
   logic          ki;
   logic          err_clr;
   logic          busy;
   logic          timeout_err;
   logic [CW-1:0] wave_cnt;

   int           tests     = 0;
   int           fails     = 0;
   int           completed = 0;
   logic [W-1:0] exp_q[$];
   bit           mon_en    = 1'b0;

   ncl_dualrail_wavefront_src #(.WIDTH(W), .TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .rail1(rail1), .rail0(rail0), .ki(ki),
      .err_clr(err_clr), .busy(busy), .timeout_err(timeout_err),
      .wave_cnt(wave_cnt)
   );

   always #5 clk = ~clk;

   function automatic void check(input bit ok, input string name, input int act, input int req);
      tests = tests + 1;
      if (!ok) begin
         fails = fails + 1;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endfunction

   // Monitor: pops the scoreboard on each new DATA wavefront, checks every cycle.
   initial begin
      logic [W-1:0] cur_exp;
      bit           prev_null;
      cur_exp   = '0;
      prev_null = 1'b1;
      forever begin
         @(negedge clk);
         if (mon_en && !rst) begin
            check((rail1 & rail0) == '0, "rail_overlap", int'(rail1 & rail0), 0);
            if ((rail1 | rail0) != '0) begin
               if (prev_null) begin
                  if (exp_q.size() == 0) check(1'b0, "unexpected_wave", int'(rail1), -1);
                  else cur_exp = exp_q.pop_front();
               end
               check((rail1 == cur_exp) && (rail0 == ~cur_exp), "wave_data",
                     int'({rail1, rail0}), int'({cur_exp, ~cur_exp}));
               prev_null = 1'b0;
            end else begin
               prev_null = 1'b1;
            end
         end
      end
   end

   task automatic wait_ready(input string name);
      bit got;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         if (in_ready) got = 1'b1;
         else @(negedge clk);
      end
      check(got, name, int'(in_ready), 1);
   endtask

   // Present a word, then act as the downstream ki responder with a delay.
   task automatic send_word(input logic [W-1:0] w, input int dly, input bit hold);
      bit got;
      int n;
      in_data  = w;
      in_valid = 1'b1;
      got      = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
         if (in_ready) got = 1'b1;
         else @(negedge clk);
      end
      check(got, "accept_wait", int'(in_ready), 1);
      if (got) begin
         exp_q.push_back(w);
         @(negedge clk);
         if (!hold) in_valid = 1'b0;
         check((rail1 == w) && (rail0 == ~w), "data_latency", int'({rail1, rail0}), int'({w, ~w}));
         check(busy == 1'b1, "busy_data", int'(busy), 1);
         repeat (dly) @(negedge clk);
         ki = 1'b0;
         n  = 0;
         for (int k = 1; k <= 10 && n == 0; k++) begin
            @(negedge clk);
            if ((rail1 | rail0) == '0) n = k;
         end
         check(n == 3, "null_latency", n, 3);
         repeat (dly) @(negedge clk);
         ki        = 1'b1;
         completed = completed + 1;
      end
   endtask

   initial begin
      int low_cnt;
      int k;
      bit found;
      int gap;
      logic [W-1:0] w;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      ki       = 1'b0;
      err_clr  = 1'b0;
      repeat (3) @(negedge clk);
      check((rail1 | rail0) == '0, "rst_rails", int'({rail1, rail0}), 0);
      check(in_ready == 1'b0, "rst_in_ready", int'(in_ready), 0);
      check(busy == 1'b0, "rst_busy", int'(busy), 0);
      check(timeout_err == 1'b0, "rst_timeout_err", int'(timeout_err), 0);
      check(wave_cnt == '0, "rst_wave_cnt", int'(wave_cnt), 0);
      ki = 1'b1;
      @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;
      wait_ready("ready_after_reset");

      // Single word 1010.
      send_word(4'b1010, 0, 1'b0);
      wait_ready("ready_after_single");
      check(int'(wave_cnt) == completed % 16, "wave_cnt_single", int'(wave_cnt), completed % 16);
      check(busy == 1'b0, "busy_idle", int'(busy), 0);

      // Back-to-back stream 0..F with in_valid held high.
      for (int i = 0; i < 16; i++) send_word(4'(i), 1, 1'b1);
      in_valid = 1'b0;
      wait_ready("ready_after_stream");
      check(int'(wave_cnt) == completed % 16, "wave_cnt_stream", int'(wave_cnt), completed % 16);

      // Randomized words, responder delays and gaps.
      for (int i = 0; i < 20; i++) begin
         gap = int'($urandom_range(0, 2));
         if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
         end
         send_word(4'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
      end
      in_valid = 1'b0;
      wait_ready("ready_after_random");
      check(int'(wave_cnt) == completed % 16, "wave_cnt_random", int'(wave_cnt), completed % 16);

      // ki glitch while idle: in_ready drops for exactly one cycle, two cycles late.
      ki = 1'b0;
      @(negedge clk);
      ki = 1'b1;
      check(in_ready == 1'b1, "glitch_delay", int'(in_ready), 1);
      low_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!in_ready) low_cnt++;
         check((rail1 | rail0) == '0, "glitch_rails", int'({rail1, rail0}), 0);
      end
      check(low_cnt == 1, "glitch_ready_low", low_cnt, 1);
      check(timeout_err == 1'b0, "glitch_no_err", int'(timeout_err), 0);
      check(int'(wave_cnt) == completed % 16, "glitch_wave_cnt", int'(wave_cnt), completed % 16);

      // Timeout: ki stays high after a word is accepted.
      wait_ready("ready_before_timeout");
      w        = 4'($urandom);
      in_data  = w;
      in_valid = 1'b1;
      exp_q.push_back(w);
      @(negedge clk);
      in_valid = 1'b0;
      k        = 0;
      found    = 1'b0;
      while (k < 20 && !found) begin
         if (timeout_err) found = 1'b1;
         else begin
            @(negedge clk);
            k++;
         end
      end
      check(found && (k >= 8) && (k <= 9), "timeout_cycles", k, 8);
      check((rail1 | rail0) == '0, "err_rails", int'({rail1, rail0}), 0);
      check(in_ready == 1'b0, "err_in_ready", int'(in_ready), 0);
      check(busy == 1'b0, "err_busy", int'(busy), 0);
      check(int'(wave_cnt) == completed % 16, "err_wave_cnt", int'(wave_cnt), completed % 16);
      @(negedge clk);
      check(timeout_err == 1'b1, "err_sticky", int'(timeout_err), 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check(timeout_err == 1'b0, "err_clr_flag", int'(timeout_err), 0);
      check(in_ready == 1'b1, "err_clr_ready", int'(in_ready), 1);

      // Reset while DATA is on the rails: rails clear without waiting for a clock.
      w        = 4'b0110;
      in_data  = w;
      in_valid = 1'b1;
      exp_q.push_back(w);
      @(negedge clk);
      in_valid = 1'b0;
      check((rail1 == w) && (rail0 == ~w), "pre_rst_data", int'({rail1, rail0}), int'({w, ~w}));
      rst = 1'b1;
      #1;
      check((rail1 | rail0) == '0, "async_rst_rails", int'({rail1, rail0}), 0);
      check(wave_cnt == '0, "async_rst_wave_cnt", int'(wave_cnt), 0);
      check(busy == 1'b0, "async_rst_busy", int'(busy), 0);
      completed = 0;
      @(negedge clk);
      rst = 1'b0;
      wait_ready("ready_after_rst");
      send_word(4'($urandom), 1, 1'b0);
      wait_ready("ready_post_rst_word");
      check(int'(wave_cnt) == 1, "post_rst_wave_cnt", int'(wave_cnt), 1);

      // Counter wrap: 17 wavefronts since reset on a 4-bit counter.
      for (int i = 0; i < 16; i++) send_word(4'($urandom), int'($urandom_range(0, 2)), 1'b0);
      wait_ready("ready_after_wrap");
      check(int'(wave_cnt) == completed % 16, "wave_cnt_wrap", int'(wave_cnt), 1);

      repeat (3) @(negedge clk);
      check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got %0d tests, required completion", tests);
      $fatal(1, "watchdog");
   end

endmodule
